rgb2gray: RTL

RGB2GRAY -- requirements
Module: rgb2gray

---
 rtl/rgb2gray.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rgb2gray.sv
// -----------------------------------------------------------------------------
// rgb2gray -- AXI4-Stream RGB888 to 8-bit luma converter
//
// Y = (77*R + 150*G + 29*B + 128) >> 8, two-stage pipeline with a global
// stall enable so the output beat holds while downstream is not ready.
//
// Parameters
//   width   active pixels per line  (frame checker only)
//   height  lines per frame         (frame checker only)
//
// Ports
//   clk              sole clock, rising edge
//   reset            asynchronous active-low reset
//   AXIS_In_tData    RGB pixel: R [23:16], G [15:8], B [7:0]
//   AXIS_In_tValid   upstream data valid
//   AXIS_In_tReady   block accepts input (the pipeline enable)
//   AXIS_In_tUser    start of frame
//   AXIS_In_tLast    end of line
//   AXIS_Out_tData   grayscale pixel
//   AXIS_Out_tValid  output data valid
//   AXIS_Out_tReady  downstream ready
//   AXIS_Out_tUser   start of frame, aligned with its pixel
//   AXIS_Out_tLast   end of line, aligned with its pixel
//   frame_err        sticky framing-error flag
//
// Optional feature: define RGB2GRAY_FRAME_CHECK_EN to enable x/y position
// counters and the framing checker. Without it frame_err is tied to 0.
// The datapath is the same in both builds.
// -----------------------------------------------------------------------------
module rgb2gray #(
    parameter int width  = 240,
    parameter int height = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] AXIS_In_tData,
    input  logic        AXIS_In_tValid,
    output logic        AXIS_In_tReady,
    input  logic        AXIS_In_tUser,
    input  logic        AXIS_In_tLast,
    output logic [7:0]  AXIS_Out_tData,
    output logic        AXIS_Out_tValid,
    input  logic        AXIS_Out_tReady,
    output logic        AXIS_Out_tUser,
    output logic        AXIS_Out_tLast,
    output logic        frame_err
);

    localparam int STAGES = 2;

    if (width < 2 || height < 1) begin : g_param_chk
        $error("rgb2gray: width must be >= 2 and height >= 1");
    end

    // Reset: asserts asynchronously, releases after two clk edges.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Pipeline enable. Held low until the synchronised release so nothing is
    // accepted while the pipeline is still in reset.
    logic [STAGES:1] r_vld_pipe;
    logic            w_en;
    logic            w_fire;

    assign w_en           = w_rst_n & (~r_vld_pipe[STAGES] | AXIS_Out_tReady);
    assign AXIS_In_tReady = w_en;
    assign w_fire         = AXIS_In_tValid & w_en;

    // Stage 1: weighted products (each fits 16 bits; their sum plus the
    // rounding constant peaks at 65408, so no overflow anywhere).
    logic [15:0] w_r, w_g, w_b;
    logic [15:0] r_p_r, r_p_g, r_p_b;
    logic        r_user1, r_last1;
    // Stage 2: rounded luma.
    logic [15:0] w_sum;
    logic [7:0]  r_gray;
    logic        r_user2, r_last2;

    assign w_r   = {8'd0, AXIS_In_tData[23:16]};
    assign w_g   = {8'd0, AXIS_In_tData[15:8]};
    assign w_b   = {8'd0, AXIS_In_tData[7:0]};
    assign w_sum = r_p_r + r_p_g + r_p_b + 16'd128;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vld_pipe <= '0;
            r_p_r      <= '0;
            r_p_g      <= '0;
            r_p_b      <= '0;
            r_user1    <= 1'b0;
            r_last1    <= 1'b0;
            r_gray     <= '0;
            r_user2    <= 1'b0;
            r_last2    <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], AXIS_In_tValid};
            // Data registers load only behind a valid beat so bubbles leave
            // the last real pixel in place.
            if (AXIS_In_tValid) begin
                r_p_r   <= w_r * 16'd77;
                r_p_g   <= w_g * 16'd150;
                r_p_b   <= w_b * 16'd29;
                r_user1 <= AXIS_In_tUser;
                r_last1 <= AXIS_In_tLast;
            end
            if (r_vld_pipe[1]) begin
                r_gray  <= 8'(w_sum >> 8);
                r_user2 <= r_user1;
                r_last2 <= r_last1;
            end
        end
    end

    assign AXIS_Out_tValid = r_vld_pipe[STAGES];
    assign AXIS_Out_tData  = r_gray;
    assign AXIS_Out_tUser  = r_user2;
    assign AXIS_Out_tLast  = r_last2;

`ifdef RGB2GRAY_FRAME_CHECK_EN
    localparam int XW = $clog2(width);
    localparam int YW = (height > 1) ? $clog2(height) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(height - 1);

    logic [XW-1:0] r_x, w_x_cur;
    logic [YW-1:0] r_ycnt, w_y_cur;
    logic          r_frame_err;
    logic          w_x_end, w_y_end, w_bad;

    // A tUser beat is position (0,0) by definition; check and count from there.
    always_comb begin
        w_x_cur = AXIS_In_tUser ? '0 : r_x;
        w_y_cur = AXIS_In_tUser ? '0 : r_ycnt;
        w_x_end = (w_x_cur == X_LAST);
        w_y_end = (w_y_cur == Y_LAST);
        w_bad   = (AXIS_In_tUser & ((r_x != '0) | (r_ycnt != '0)))
                | (AXIS_In_tLast != w_x_end);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_x         <= '0;
            r_ycnt      <= '0;
            r_frame_err <= 1'b0;
        end else if (w_fire) begin
            r_frame_err <= r_frame_err | w_bad;
            if (w_x_end) begin
                r_x    <= '0;
                r_ycnt <= w_y_end ? '0 : w_y_cur + YW'(1);
            end else begin
                r_x    <= w_x_cur + XW'(1);
                r_ycnt <= w_y_cur;
            end
        end
    end

    assign frame_err = r_frame_err;
`else
    logic w_unused;
    assign w_unused  = w_fire & AXIS_In_tUser & AXIS_In_tLast;
    assign frame_err = 1'b0;
`endif

endmodule
